sprite_table: RTL and testbench

SPRITE_TABLE -- requirements
Module: sprite_table

---
 rtl/sprite_pkg.sv | 30 +++
 rtl/sprite_table_if.sv | 47 ++++
 rtl/sprite_prio_enc.sv | 29 ++
 rtl/sprite_table.sv | 200 ++++++++++++++++++++
 tb/tb_sprite_table.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg -- shared types and defaults for the sprite object table.
//   DEF_*          default values for the sprite_table parameters
//   OBJ_*_MAX      storage widths of obj_t fields; COORD_W must not exceed
//                  OBJ_COORD_MAX and SIZE_W must not exceed OBJ_SIZE_MAX
//   obj_t          one object slot: visible, mirror, top-left corner, size
//   ext_t          coordinate width plus one carry bit for end-of-span sums
package sprite_pkg;

  localparam int unsigned DEF_N_OBJ   = 8;
  localparam int unsigned DEF_COORD_W = 10;
  localparam int unsigned DEF_SIZE_W  = 6;

  localparam int unsigned OBJ_COORD_MAX = 16;
  localparam int unsigned OBJ_SIZE_MAX  = 12;
  localparam int unsigned EXT_W         = OBJ_COORD_MAX + 1;

  typedef struct packed {
    logic                     vis;
    logic                     dir;
    logic [OBJ_COORD_MAX-1:0] x;
    logic [OBJ_COORD_MAX-1:0] y;
    logic [OBJ_SIZE_MAX-1:0]  w;
    logic [OBJ_SIZE_MAX-1:0]  h;
  } obj_t;

  typedef logic [EXT_W-1:0] ext_t;

  localparam obj_t OBJ_CLEAR = '0;

endpackage

// File: rtl/sprite_table_if.sv
// sprite_table_if -- bus between a sprite table and its host/video timing.
//   master : drives slot writes (wr_*), vsync and the pixel position (vgaX/vgaY);
//            receives hit, hit_idx, off_x, off_y, pending, coll_mask
//   slave  : the sprite_table side of the same signals
interface sprite_table_if
  import sprite_pkg::*;
#(
  parameter int unsigned N_OBJ   = DEF_N_OBJ,
  parameter int unsigned COORD_W = DEF_COORD_W,
  parameter int unsigned SIZE_W  = DEF_SIZE_W
);

  localparam int unsigned IDX_W = $clog2(N_OBJ);

  logic               wr_valid;
  logic [IDX_W-1:0]   wr_obj;
  logic               wr_vis;
  logic               wr_dir;
  logic [COORD_W-1:0] wr_x;
  logic [COORD_W-1:0] wr_y;
  logic [SIZE_W-1:0]  wr_w;
  logic [SIZE_W-1:0]  wr_h;

  logic               vsync;
  logic [COORD_W-1:0] vgaX;
  logic [COORD_W-1:0] vgaY;

  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic [SIZE_W-1:0]  off_x;
  logic [SIZE_W-1:0]  off_y;
  logic               pending;
  logic [N_OBJ-1:0]   coll_mask;

  modport master (
    output wr_valid, wr_obj, wr_vis, wr_dir, wr_x, wr_y, wr_w, wr_h,
    output vsync, vgaX, vgaY,
    input  hit, hit_idx, off_x, off_y, pending, coll_mask
  );

  modport slave (
    input  wr_valid, wr_obj, wr_vis, wr_dir, wr_x, wr_y, wr_w, wr_h,
    input  vsync, vgaX, vgaY,
    output hit, hit_idx, off_x, off_y, pending, coll_mask
  );

endinterface

// File: rtl/sprite_prio_enc.sv
// sprite_prio_enc -- N-input priority encoder, lowest index wins.
//   req_i   : request vector
//   valid_o : at least one request set
//   idx_o   : index of lowest set request (0 when none)
module sprite_prio_enc #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         req_i,
  output logic                 valid_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int unsigned IDX_W = $clog2(N);

  logic found;

  always_comb begin
    found = 1'b0;
    idx_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_i[i] && !found) begin
        found = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/sprite_table.sv
// sprite_table -- double-buffered sprite object table with per-pixel lookup.
//   Clk   : system clock, rising edge
//   Reset : synchronous, active high
//   bus   : sprite_table_if.slave
//     wr_valid/wr_obj/wr_vis/wr_dir/wr_x/wr_y/wr_w/wr_h : shadow slot write
//     vsync (active low) : falling edge of registered vsync commits shadow -> active
//     vgaX/vgaY          : pixel position, looked up with 2-cycle latency
//     hit/hit_idx/off_x/off_y : lowest-index covering object and pixel offset
//     pending   : shadow holds writes not yet committed
//     coll_mask : per-object overlap flags latched at commit
// Optional feature: define SPRITE_COLLIDE_EN to build the overlap accumulator;
// otherwise coll_mask is tied to zero.
module sprite_table
  import sprite_pkg::*;
#(
  parameter int unsigned N_OBJ   = DEF_N_OBJ,
  parameter int unsigned COORD_W = DEF_COORD_W,
  parameter int unsigned SIZE_W  = DEF_SIZE_W
) (
  input  logic         Clk,
  input  logic         Reset,
  sprite_table_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(N_OBJ);

  // ---------------------------------------------------------------------
  // Shadow / active tables, vsync edge detect, pending flag
  // ---------------------------------------------------------------------
  obj_t shadow_q [N_OBJ];
  obj_t act_q    [N_OBJ];
  obj_t wr_ent;

  logic vs_q, vs_hist_q;
  logic commit;
  logic wr_accept;
  logic pending_q, pending_d;

  assign commit    = vs_hist_q & ~vs_q;
  assign wr_accept = bus.wr_valid && (32'(bus.wr_obj) < N_OBJ);

  always_comb begin
    wr_ent     = OBJ_CLEAR;
    wr_ent.vis = bus.wr_vis;
    wr_ent.dir = bus.wr_dir;
    wr_ent.x   = OBJ_COORD_MAX'(bus.wr_x);
    wr_ent.y   = OBJ_COORD_MAX'(bus.wr_y);
    wr_ent.w   = OBJ_SIZE_MAX'(bus.wr_w);
    wr_ent.h   = OBJ_SIZE_MAX'(bus.wr_h);
  end

  always_comb begin
    pending_d = pending_q;
    if (wr_accept) begin
      pending_d = 1'b1;
    end else if (commit) begin
      pending_d = 1'b0;
    end
  end

  // The commit copies the registered shadow, so a write accepted in the
  // commit cycle lands in shadow only and waits for the next commit.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < N_OBJ; i++) begin
        shadow_q[i] <= OBJ_CLEAR;
        act_q[i]    <= OBJ_CLEAR;
      end
      vs_q      <= 1'b1;
      vs_hist_q <= 1'b1;
      pending_q <= 1'b0;
    end else begin
      vs_q      <= bus.vsync;
      vs_hist_q <= vs_q;
      pending_q <= pending_d;
      if (commit) begin
        for (int unsigned i = 0; i < N_OBJ; i++) begin
          act_q[i] <= shadow_q[i];
        end
      end
      if (wr_accept) begin
        shadow_q[bus.wr_obj] <= wr_ent;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: parallel compare against the active table
  // ---------------------------------------------------------------------
  ext_t              px, py;
  logic [N_OBJ-1:0]  cover_d, cover_q;
  logic [SIZE_W-1:0] offx_d [N_OBJ];
  logic [SIZE_W-1:0] offy_d [N_OBJ];
  logic [SIZE_W-1:0] offx_s1_q [N_OBJ];
  logic [SIZE_W-1:0] offy_s1_q [N_OBJ];

  // Spans are compared one bit wider than the coordinate so x+w never wraps;
  // a zero width or height gives an empty span and can never cover.
  always_comb begin
    px      = ext_t'(bus.vgaX);
    py      = ext_t'(bus.vgaY);
    cover_d = '0;
    for (int unsigned i = 0; i < N_OBJ; i++) begin
      cover_d[i] = act_q[i].vis
                && (px >= ext_t'(act_q[i].x))
                && (px <  ext_t'(act_q[i].x) + ext_t'(act_q[i].w))
                && (py >= ext_t'(act_q[i].y))
                && (py <  ext_t'(act_q[i].y) + ext_t'(act_q[i].h));
      offx_d[i]  = act_q[i].dir
                 ? SIZE_W'(ext_t'(act_q[i].w) - ext_t'(1) - (px - ext_t'(act_q[i].x)))
                 : SIZE_W'(px - ext_t'(act_q[i].x));
      offy_d[i]  = SIZE_W'(py - ext_t'(act_q[i].y));
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cover_q <= '0;
      for (int unsigned i = 0; i < N_OBJ; i++) begin
        offx_s1_q[i] <= '0;
        offy_s1_q[i] <= '0;
      end
    end else begin
      cover_q <= cover_d;
      for (int unsigned i = 0; i < N_OBJ; i++) begin
        offx_s1_q[i] <= offx_d[i];
        offy_s1_q[i] <= offy_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: priority select
  // ---------------------------------------------------------------------
  logic              sel_valid;
  logic [IDX_W-1:0]  sel_idx;
  logic              hit_q;
  logic [IDX_W-1:0]  idx_q;
  logic [SIZE_W-1:0] offx_q, offy_q;

  sprite_prio_enc #(
    .N (N_OBJ)
  ) u_prio (
    .req_i   (cover_q),
    .valid_o (sel_valid),
    .idx_o   (sel_idx)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hit_q  <= 1'b0;
      idx_q  <= '0;
      offx_q <= '0;
      offy_q <= '0;
    end else begin
      hit_q  <= sel_valid;
      idx_q  <= sel_valid ? sel_idx : '0;
      offx_q <= sel_valid ? offx_s1_q[sel_idx] : '0;
      offy_q <= sel_valid ? offy_s1_q[sel_idx] : '0;
    end
  end

  assign bus.hit     = hit_q;
  assign bus.hit_idx = idx_q;
  assign bus.off_x   = offx_q;
  assign bus.off_y   = offy_q;
  assign bus.pending = pending_q;

  // ---------------------------------------------------------------------
  // Collision accumulator
  // ---------------------------------------------------------------------
`ifdef SPRITE_COLLIDE_EN
  logic [N_OBJ-1:0] acc_q, acc_d, coll_q;
  logic             multi;

  // More than one bit set: clearing the lowest set bit leaves something.
  always_comb begin
    multi = |(cover_q & (cover_q - N_OBJ'(1)));
    acc_d = acc_q | (multi ? cover_q : '0);
  end

  // The mask loads the accumulator including this cycle's overlaps.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc_q  <= '0;
      coll_q <= '0;
    end else if (commit) begin
      coll_q <= acc_d;
      acc_q  <= '0;
    end else begin
      acc_q  <= acc_d;
    end
  end

  assign bus.coll_mask = coll_q;
`else
  assign bus.coll_mask = '0;
`endif

endmodule

// File: tb/tb_sprite_table.sv
module tb_sprite_table;

  localparam int unsigned N_OBJ   = 8;
  localparam int unsigned COORD_W = 10;
  localparam int unsigned SIZE_W  = 6;

`ifdef SPRITE_COLLIDE_EN
  localparam logic [N_OBJ-1:0] COLL_EXP = 8'h24;
`else
  localparam logic [N_OBJ-1:0] COLL_EXP = 8'h00;
`endif

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  sprite_table_if #(.N_OBJ(N_OBJ), .COORD_W(COORD_W), .SIZE_W(SIZE_W)) bus ();

  sprite_table #(.N_OBJ(N_OBJ), .COORD_W(COORD_W), .SIZE_W(SIZE_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [COORD_W-1:0] px;
    logic [COORD_W-1:0] py;
    logic               hit;
    logic [2:0]         idx;
    logic [SIZE_W-1:0]  ox;
    logic [SIZE_W-1:0]  oy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Lookup tag delayed by the design's 2-cycle latency marks valid output.
  logic       look_v = 1'b0;
  logic [1:0] vd     = '0;
  always @(posedge Clk) vd <= {vd[0], look_v};

  always @(negedge Clk) begin : monitor
    exp_t e;
    if (vd[1]) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL lookup: output with no expected entry queued");
      end else begin
        e = exp_q.pop_front();
        if ({bus.hit, bus.hit_idx, bus.off_x, bus.off_y} !== {e.hit, e.idx, e.ox, e.oy}) begin
          n_fail++;
          $display("FAIL lookup(%0d,%0d): got hit=%0d idx=%0d off=(%0d,%0d) expected hit=%0d idx=%0d off=(%0d,%0d)",
                   e.px, e.py, bus.hit, bus.hit_idx, bus.off_x, bus.off_y, e.hit, e.idx, e.ox, e.oy);
        end
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic lookup(input int x, input int y, input logic h, input int idx, input int ox, input int oy);
    exp_t e;
    step();
    bus.vgaX = COORD_W'(x);
    bus.vgaY = COORD_W'(y);
    e.px  = COORD_W'(x);
    e.py  = COORD_W'(y);
    e.hit = h;
    e.idx = 3'(idx);
    e.ox  = SIZE_W'(ox);
    e.oy  = SIZE_W'(oy);
    exp_q.push_back(e);
    look_v = 1'b1;
    step();
    look_v = 1'b0;
    bus.vgaX = '0;          // park on a pixel nothing covers
    bus.vgaY = '1;
  endtask

  task automatic set_wr(input int slot, input logic vis, input logic dir,
                        input int x, input int y, input int w, input int h);
    bus.wr_obj = 3'(slot);
    bus.wr_vis = vis;
    bus.wr_dir = dir;
    bus.wr_x   = COORD_W'(x);
    bus.wr_y   = COORD_W'(y);
    bus.wr_w   = SIZE_W'(w);
    bus.wr_h   = SIZE_W'(h);
  endtask

  task automatic write(input int slot, input logic vis, input logic dir,
                       input int x, input int y, input int w, input int h);
    step();
    set_wr(slot, vis, dir, x, y, w, h);
    bus.wr_valid = 1'b1;
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic commit();
    step();
    bus.vsync = 1'b0;
    repeat (3) step();
    bus.vsync = 1'b1;
    repeat (3) step();
  endtask

  // Write issued exactly in the cycle the commit takes effect.
  task automatic commit_with_write(input int slot, input int x, input int y, input int w, input int h);
    step();
    bus.vsync = 1'b0;
    step();
    set_wr(slot, 1'b1, 1'b0, x, y, w, h);
    bus.wr_valid = 1'b1;
    step();
    bus.wr_valid = 1'b0;
    step();
    bus.vsync = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_valid = 1'b0;
    set_wr(0, 1'b0, 1'b0, 0, 0, 0, 0);
    bus.vsync = 1'b1;
    bus.vgaX  = '0;
    bus.vgaY  = '1;
    repeat (3) step();
    Reset = 1'b0;
    step();

    // Reset state
    check("reset hit", 32'(bus.hit), 0);
    check("reset hit_idx", 32'(bus.hit_idx), 0);
    check("reset pending", 32'(bus.pending), 0);
    check("reset coll_mask", 32'(bus.coll_mask), 0);
    lookup(100, 50, 1'b0, 0, 0, 0);

    // Basic object, facing right
    write(0, 1'b1, 1'b0, 100, 50, 16, 32);
    check("pending after write", 32'(bus.pending), 1);
    commit();
    check("pending after commit", 32'(bus.pending), 0);
    lookup(100, 50, 1'b1, 0, 0, 0);
    lookup(116, 50, 1'b0, 0, 0, 0);
    lookup(115, 81, 1'b1, 0, 15, 31);
    lookup(99, 50, 1'b0, 0, 0, 0);
    lookup(100, 82, 1'b0, 0, 0, 0);
    lookup(107, 60, 1'b1, 0, 7, 10);

    // Mirrored
    write(0, 1'b1, 1'b1, 100, 50, 16, 32);
    commit();
    lookup(100, 50, 1'b1, 0, 15, 0);
    lookup(115, 50, 1'b1, 0, 0, 0);
    lookup(105, 53, 1'b1, 0, 10, 3);

    // Shadow write without commit stays invisible
    write(3, 1'b1, 1'b0, 300, 300, 8, 8);
    check("pending slot3 uncommitted", 32'(bus.pending), 1);
    lookup(302, 301, 1'b0, 0, 0, 0);
    lookup(100, 50, 1'b1, 0, 15, 0);
    commit();
    check("pending slot3 committed", 32'(bus.pending), 0);
    lookup(302, 301, 1'b1, 3, 2, 1);

    // Write coincident with commit
    commit_with_write(4, 400, 400, 4, 4);
    check("pending coincident write", 32'(bus.pending), 1);
    lookup(401, 401, 1'b0, 0, 0, 0);
    commit();
    check("pending after second commit", 32'(bus.pending), 0);
    lookup(401, 401, 1'b1, 4, 1, 1);

    // Overlap: lowest index wins, collision mask
    write(2, 1'b1, 1'b0, 190, 190, 20, 20);
    write(5, 1'b1, 1'b0, 195, 195, 10, 10);
    commit();
    check("coll_mask before overlap", 32'(bus.coll_mask), 0);
    lookup(200, 200, 1'b1, 2, 10, 10);
    lookup(191, 191, 1'b1, 2, 1, 1);
    commit();
    check("coll_mask after overlap", 32'(bus.coll_mask), 32'(COLL_EXP));
    commit();
    check("coll_mask cleared", 32'(bus.coll_mask), 0);

    // No wrap at right edge; zero-sized objects
    write(1, 1'b1, 1'b0, 1020, 0, 16, 8);
    write(6, 1'b1, 1'b0, 500, 500, 0, 8);
    write(7, 1'b1, 1'b0, 600, 600, 8, 0);
    commit();
    lookup(2, 0, 1'b0, 0, 0, 0);
    lookup(2, 5, 1'b0, 0, 0, 0);
    lookup(1023, 0, 1'b1, 1, 3, 0);
    lookup(500, 500, 1'b0, 0, 0, 0);
    lookup(600, 600, 1'b0, 0, 0, 0);

    // Reset mid-line
    step();
    bus.vgaX = 10'd100;
    bus.vgaY = 10'd50;
    repeat (3) step();
    check("hit before reset", 32'(bus.hit), 1);
    write(3, 1'b1, 1'b0, 320, 320, 8, 8);
    check("pending before reset", 32'(bus.pending), 1);
    Reset = 1'b1;
    step();
    check("hit after reset", 32'(bus.hit), 0);
    check("pending after reset", 32'(bus.pending), 0);
    check("coll_mask after reset", 32'(bus.coll_mask), 0);
    Reset = 1'b0;
    lookup(100, 50, 1'b0, 0, 0, 0);
    lookup(302, 301, 1'b0, 0, 0, 0);

    repeat (5) step();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected lookups never produced, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
